// File: rtl/iter_shifter_pkg.sv
// Shared types for the iterative shifter: shift-mode and FSM-state enums.
package shifter_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROL = 2'b11
    } sh_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/iter_shifter_if.sv
// Request/result handshake bundle of iter_shifter; the requester uses master, the shifter slave.
interface iter_shifter_if
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [MODE_W-1:0]  in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iter_shifter_stage.sv
// One combinational shift step of k bits (k <= STEP) in the selected mode.
// The rotate wrap path exists only when ITER_SHIFTER_ROTATE_EN is defined; otherwise ROL decodes as SLL.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int K_W  = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [K_W-1:0]   k,
    input  sh_mode_e         mode,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] fill_s;
`ifdef ITER_SHIFTER_ROTATE_EN
    logic [31:0]      wrap_s;
`endif

    // Select the k-bit step; SRA ORs the latched sign into the vacated MSBs.
    always_comb begin
        fill_s = ~({WIDTH{1'b1}} >> k);
`ifdef ITER_SHIFTER_ROTATE_EN
        wrap_s = 32'(WIDTH) - 32'(k);
`endif
        case (mode)
            SH_SLL:  result = data << k;
            SH_SRL:  result = data >> k;
            SH_SRA:  result = (data >> k) | (sign ? fill_s : {WIDTH{1'b0}});
`ifdef ITER_SHIFTER_ROTATE_EN
            SH_ROL:  result = (data << k) | (data >> wrap_s);
`else
            SH_ROL:  result = data << k;
`endif
            default: result = data << k;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: up to STEP bits per clock, result held on a valid/ready output.
// Optional rotate (mode 11) is enabled by defining ITER_SHIFTER_ROTATE_EN.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    iter_shifter_if.slave bus
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int K_W     = $clog2(STEP) + 1;
    localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W + 1)'(STEP);

    state_e             state_r;
    logic [WIDTH-1:0]   work_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [SHAMT_W-1:0] remaining_r;
    sh_mode_e           mode_r;
    logic               sign_r;
    logic               out_valid_r;

    logic [SHAMT_W-1:0] amt_s;
    logic [SHAMT_W-1:0] rem_next_s;
    logic [K_W-1:0]     k_s;
    logic [WIDTH-1:0]   stage_in_s;
    logic [WIDTH-1:0]   stage_out_s;
    sh_mode_e           stage_mode_s;
    logic               stage_sign_s;

    // The first step overlaps the accept edge, giving max(1, ceil(shamt/STEP)) cycles of latency.
    always_comb begin
        if (state_r == ST_IDLE) begin
            amt_s        = bus.in_shamt;
            stage_in_s   = bus.in_data;
            stage_mode_s = sh_mode_e'(bus.in_mode);
            stage_sign_s = bus.in_data[WIDTH-1];
        end else begin
            amt_s        = remaining_r;
            stage_in_s   = work_r;
            stage_mode_s = mode_r;
            stage_sign_s = sign_r;
        end
        if ({1'b0, amt_s} >= STEP_C) begin
            k_s = K_W'(STEP);
        end else begin
            k_s = K_W'(amt_s);
        end
        rem_next_s = amt_s - SHAMT_W'(k_s);
    end

    shift_stage #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_stage (
        .data   (stage_in_s),
        .k      (k_s),
        .mode   (stage_mode_s),
        .sign   (stage_sign_s),
        .result (stage_out_s)
    );

    // Control FSM, work register, remaining counter and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            work_r      <= {WIDTH{1'b0}};
            out_data_r  <= {WIDTH{1'b0}};
            remaining_r <= {SHAMT_W{1'b0}};
            mode_r      <= SH_SLL;
            sign_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        work_r      <= stage_out_s;
                        mode_r      <= sh_mode_e'(bus.in_mode);
                        sign_r      <= bus.in_data[WIDTH-1];
                        remaining_r <= rem_next_s;
                        if (rem_next_s == {SHAMT_W{1'b0}}) begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            out_data_r  <= stage_out_s;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_r      <= stage_out_s;
                    remaining_r <= rem_next_s;
                    if (rem_next_s == {SHAMT_W{1'b0}}) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        out_data_r  <= stage_out_s;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: one STEP=1 and one STEP=4 instance sharing a stimulus driver.
module tb_iter_shifter;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    bit          sel = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_ready = 1'b0;
    logic [31:0] drv_data = 32'h0;
    logic [4:0]  drv_shamt = 5'd0;
    logic [1:0]  drv_mode = 2'b00;
    int          nvec = 0;
    int          nfail = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    iter_shifter_if #(.WIDTH(32)) if1 ();
    iter_shifter_if #(.WIDTH(32)) if4 ();

    iter_shifter #(.WIDTH(32), .STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    iter_shifter #(.WIDTH(32), .STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    assign if1.in_valid  = drv_valid & ~sel;
    assign if4.in_valid  = drv_valid & sel;
    assign if1.out_ready = drv_ready & ~sel;
    assign if4.out_ready = drv_ready & sel;
    assign if1.in_data   = drv_data;
    assign if4.in_data   = drv_data;
    assign if1.in_shamt  = drv_shamt;
    assign if4.in_shamt  = drv_shamt;
    assign if1.in_mode   = drv_mode;
    assign if4.in_mode   = drv_mode;

    wire        obs_in_ready  = sel ? if4.in_ready  : if1.in_ready;
    wire        obs_out_valid = sel ? if4.out_valid : if1.out_valid;
    wire [31:0] obs_out_data  = sel ? if4.out_data  : if1.out_data;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
        logic [31:0] r;
        case (m)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = $signed(d) >>> s;
`ifdef ITER_SHIFTER_ROTATE_EN
            2'b11: r = (s == 5'd0) ? d : ((d << s) | (d >> (6'd32 - {1'b0, s})));
`else
            2'b11: r = d << s;
`endif
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [4:0] s, input int step);
        return (s == 5'd0) ? 1 : ((int'(s) + step - 1) / step);
    endfunction

    task automatic accept_req(input bit s, input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m, input bit keep);
        int w;
        exp_t e;
        sel = s; drv_data = d; drv_shamt = sh; drv_mode = m; drv_valid = 1'b1;
        w = 0;
        while (!obs_in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        nvec++;
        if (!obs_in_ready) begin
            nfail++;
            $display("FAIL accept_timeout: in_ready got %b want 1", obs_in_ready);
        end
        @(posedge clk); #1;
        if (!keep) drv_valid = 1'b0;
        e.data = ref_shift(d, sh, m);
        e.lat  = ref_lat(sh, s ? 4 : 1);
        sb.push_back(e);
    endtask

    task automatic collect(output int lat, output logic [31:0] d);
        lat = 1;
        while (!obs_out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        d = obs_out_data;
    endtask

    task automatic release_out();
        drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            sel = bit'(i);
            #1;
            nvec += 3;
            if (obs_in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready: got %b want 1", obs_in_ready); end
            if (obs_out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid: got %b want 0", obs_out_valid); end
            if (obs_out_data !== 32'h0) begin nfail++; $display("FAIL reset_out_data: got %h want 0", obs_out_data); end
        end
    endtask

    task automatic test_vector(input string nm, input bit s, input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m);
        int lat;
        logic [31:0] r;
        exp_t e;
        accept_req(s, d, sh, m, 1'b0);
        collect(lat, r);
        e = sb.pop_front();
        nvec += 2;
        if (r !== e.data) begin nfail++; $display("FAIL %s_data: got %h want %h", nm, r, e.data); end
        if (lat != e.lat) begin nfail++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, e.lat); end
        release_out();
    endtask

    task automatic test_srl_zero();
        int lat;
        logic [31:0] r;
        exp_t e;
        accept_req(1'b0, 32'h1234_5678, 5'd0, 2'b01, 1'b0);
        collect(lat, r);
        e = sb.pop_front();
        nvec += 2;
        if (r !== e.data) begin nfail++; $display("FAIL srl0_data: got %h want %h", r, e.data); end
        if (lat != e.lat) begin nfail++; $display("FAIL srl0_latency: got %0d want %0d", lat, e.lat); end
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (obs_in_ready !== 1'b0) begin nfail++; $display("FAIL srl0_in_ready: got %b want 0", obs_in_ready); end
            @(posedge clk); #1;
        end
        release_out();
    endtask

    task automatic test_modes();
        logic [31:0] d;
        logic [4:0]  sh;
        for (int i = 0; i < 12; i++) begin
            d  = $urandom;
            sh = 5'($urandom_range(0, 31));
            if (i == 10) sh = 5'd31;
            if (i == 11) sh = 5'd4;
            test_vector("modes", bit'(i % 2), d, sh, 2'(i % 4));
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] r;
        exp_t e;
        accept_req(1'b0, 32'hA5A5_0F0F, 5'd3, 2'b01, 1'b1);
        drv_data = 32'h0000_00F0; drv_shamt = 5'd1; drv_mode = 2'b00;
        collect(lat, r);
        e = sb.pop_front();
        nvec += 2;
        if (r !== e.data) begin nfail++; $display("FAIL bp_data: got %h want %h", r, e.data); end
        if (lat != e.lat) begin nfail++; $display("FAIL bp_latency: got %0d want %0d", lat, e.lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            nvec += 3;
            if (obs_out_valid !== 1'b1) begin nfail++; $display("FAIL bp_hold_valid: got %b want 1", obs_out_valid); end
            if (obs_out_data !== e.data) begin nfail++; $display("FAIL bp_hold_data: got %h want %h", obs_out_data, e.data); end
            if (obs_in_ready !== 1'b0) begin nfail++; $display("FAIL bp_hold_in_ready: got %b want 0", obs_in_ready); end
        end
        release_out();
        nvec += 2;
        if (obs_in_ready !== 1'b1) begin nfail++; $display("FAIL bp_after_in_ready: got %b want 1", obs_in_ready); end
        if (obs_out_valid !== 1'b0) begin nfail++; $display("FAIL bp_after_out_valid: got %b want 0", obs_out_valid); end
        e.data = ref_shift(32'h0000_00F0, 5'd1, 2'b00);
        e.lat  = ref_lat(5'd1, 1);
        sb.push_back(e);
        @(posedge clk); #1;
        drv_valid = 1'b0;
        collect(lat, r);
        e = sb.pop_front();
        nvec += 2;
        if (r !== e.data) begin nfail++; $display("FAIL bp_next_data: got %h want %h", r, e.data); end
        if (lat != e.lat) begin nfail++; $display("FAIL bp_next_latency: got %0d want %0d", lat, e.lat); end
        release_out();
    endtask

    task automatic test_reset_abort();
        accept_req(1'b0, 32'h0000_0ABC, 5'd20, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (obs_out_valid !== 1'b0) begin nfail++; $display("FAIL abort_early_valid: got %b want 0", obs_out_valid); end
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if (obs_out_valid !== 1'b0) begin nfail++; $display("FAIL abort_in_reset_valid: got %b want 0", obs_out_valid); end
        sb.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        nvec += 3;
        if (obs_in_ready !== 1'b1) begin nfail++; $display("FAIL abort_in_ready: got %b want 1", obs_in_ready); end
        if (obs_out_valid !== 1'b0) begin nfail++; $display("FAIL abort_out_valid: got %b want 0", obs_out_valid); end
        if (obs_out_data !== 32'h0) begin nfail++; $display("FAIL abort_out_data: got %h want 0", obs_out_data); end
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            nvec++;
            if (obs_out_valid !== 1'b0) begin nfail++; $display("FAIL abort_late_valid: got %b want 0", obs_out_valid); end
        end
        test_vector("abort_fresh", 1'b0, 32'h0000_0ABC, 5'd20, 2'b00);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_vector("sll", 1'b0, 32'h0000_000F, 5'd2, 2'b00);
        test_vector("sra", 1'b1, 32'h8000_0000, 5'd31, 2'b10);
        test_srl_zero();
        test_vector("rol1", 1'b0, 32'h8000_0001, 5'd1, 2'b11);
        test_vector("rol4", 1'b1, 32'h8000_0001, 5'd6, 2'b11);
        test_modes();
        test_backpressure();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
